// File: rtl/spi_aes_slave_if.sv
// spi_aes_slave_if: serial slave front end for a single AES core.
// A frame of {message, key} is shifted in MSB-first on Mosi while cs is low.
// The message and key are then presented to the core together with a one-cycle
// start pulse. The core's result is shifted back out MSB-first on Miso, and
// data_done stays high for the whole result frame.
//
// Handshake: cs low qualifies Mosi on every rising edge. Once the last frame
// bit is captured, the transaction is committed, and cs is ignored until
// data_done falls. core_valid is looked at only while waiting for the core.
// A result is taken on the first edge where core_valid is seen in WAIT.
module spi_aes_slave_if #(
    parameter int nk = 8,
    parameter int nb = 4,
    parameter int nr = 14
) (
    input  logic                in_clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                Mosi,
    output logic                Miso,
    output logic                data_done,
    output logic [8*4*nb-1:0]   core_msg,
    output logic [32*nk-1:0]    core_key,
    output logic                core_start,
    input  logic [8*4*nb-1:0]   core_result,
    input  logic                core_valid,
    output logic                busy,
    output logic [2:0]          dbg_state
);

    localparam int MW  = 8 * 4 * nb;
    localparam int KW  = 32 * nk;
    localparam int TOT = MW + KW;
    localparam int CW  = $clog2(TOT + 1);

    localparam logic [CW-1:0] TOT_C = CW'(TOT);
    localparam logic [CW-1:0] MW_C  = CW'(MW);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TOT-1:0]  rx;
    logic [MW-1:0]   tx;

    logic [TOT-1:0]  rx_next;
    logic [CW-1:0]   cnt_next;

    // The shift value and the count that include the bit arriving this edge.
    // The core outputs are loaded from rx_next so that the final bit is included.
    assign rx_next   = {rx[TOT-2:0], Mosi};
    assign cnt_next  = cnt + ONE_C;
    assign dbg_state = state;

    // Transaction FSM with all outputs registered
    always_ff @(posedge in_clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rx         <= '0;
            tx         <= '0;
            core_msg   <= '0;
            core_key   <= '0;
            core_start <= 1'b0;
            Miso       <= 1'b0;
            data_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs) begin
                        rx    <= rx_next;
                        cnt   <= ONE_C;
                        state <= RECV;
                        busy  <= 1'b1;
                    end
                end
                RECV: begin
                    if (cs) begin
                        // Master gave up mid-frame: drop everything collected so far.
                        rx    <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt_next == TOT_C) begin
                        rx         <= rx_next;
                        cnt        <= '0;
                        core_msg   <= rx_next[TOT-1:KW];
                        core_key   <= rx_next[KW-1:0];
                        core_start <= 1'b1;
                        state      <= START;
                    end else begin
                        rx  <= rx_next;
                        cnt <= cnt_next;
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_valid) begin
                        tx        <= core_result;
                        Miso      <= core_result[MW-1];
                        data_done <= 1'b1;
                        cnt       <= ONE_C;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == MW_C) begin
                        // The last bit has been on the line for a full cycle.
                        Miso      <= 1'b0;
                        data_done <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        tx   <= {tx[MW-2:0], 1'b0};
                        Miso <= tx[MW-2];
                        cnt  <= cnt_next;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    core_start <= 1'b0;
                    Miso       <= 1'b0;
                    data_done  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_aes_slave_if.sv
// Testbench for spi_aes_slave_if: directed and random frames checked against
// a transaction-level model (expected msg/key and a queue of result words).
module tb_spi_aes_slave_if;

    localparam int MW  = 128;
    localparam int KW  = 256;
    localparam int TOT = MW + KW;

    // ---------------- clock / reset ----------------
    logic            in_clk = 1'b0;
    logic            rst;
    logic            cs;
    logic            Mosi;
    logic            Miso;
    logic            data_done;
    logic [MW-1:0]   core_msg;
    logic [KW-1:0]   core_key;
    logic            core_start;
    logic [MW-1:0]   core_result;
    logic            core_valid;
    logic            busy;
    logic [2:0]      dbg_state;

    always #5 in_clk = ~in_clk;

    spi_aes_slave_if #(.nk(8), .nb(4), .nr(14)) dut (
        .in_clk      (in_clk),
        .rst         (rst),
        .cs          (cs),
        .Mosi        (Mosi),
        .Miso        (Miso),
        .data_done   (data_done),
        .core_msg    (core_msg),
        .core_key    (core_key),
        .core_start  (core_start),
        .core_result (core_result),
        .core_valid  (core_valid),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int            errors = 0;
    int            checks = 0;
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] ref_msg;
    logic [KW-1:0] ref_key;

    task automatic check_val(input string tag, input logic [TOT-1:0] obs, input logic [TOT-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1ns later, inputs set right after.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic rand_bits(output logic [TOT-1:0] v);
        for (int i = 0; i < TOT / 32; i++) v[i*32 +: 32] = $urandom;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_noise(input int n);
        int bad = 0;
        cs = 1'b1;
        for (int i = 0; i < n; i++) begin
            core_valid  = 1'b1;
            core_result = {4{$urandom}};
            step();
            if (busy || data_done || Miso || core_start) bad++;
        end
        core_valid = 1'b0;
        check_val("idle_ignores_valid", bad, 0);
    endtask

    // Shift a full {msg,key} frame; the model says core_start rises after the last bit.
    task automatic send_frame(input logic [MW-1:0] msg, input logic [KW-1:0] key, input bit noise);
        logic [TOT-1:0] f;
        int starts = 0;
        int dd = 0;
        f = {msg, key};
        cs = 1'b0;
        for (int i = 0; i < TOT; i++) begin
            Mosi        = f[TOT-1-i];
            core_valid  = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
            core_result = {4{$urandom}};
            step();
            if (core_start) starts++;
            if (data_done) dd++;
        end
        Mosi = 1'b0;
        ref_msg = msg;
        ref_key = key;
        check_val("start_after_last_bit", core_start, 1);
        check_val("start_count_recv", starts, 1);
        check_val("dd_during_recv", dd, 0);
        check_val("core_msg", core_msg, ref_msg);
        check_val("core_key", core_key, ref_key);
        // core_valid during START must be ignored.
        core_valid = noise;
        step();
        core_valid = 1'b0;
        check_val("start_width", core_start, 0);
        check_val("busy_after_start", busy, 1);
        check_val("dd_after_start", data_done, 0);
    endtask

    // Wait 'latency' cycles in WAIT, then hand over a result and collect it off Miso.
    task automatic return_result(input logic [MW-1:0] res, input int latency, input bit noise);
        int bad = 0;
        int n = 0;
        logic [MW-1:0] got = '0;
        for (int i = 0; i < latency; i++) begin
            step();
            if (!busy || Miso || data_done || core_start) bad++;
        end
        check_val("wait_quiet", bad, 0);
        core_result = res;
        core_valid  = 1'b1;
        exp_q.push_back(res);
        step();
        core_valid = 1'b0;
        while (data_done && n < MW + 8) begin
            got = {got[MW-2:0], Miso};
            n++;
            core_valid  = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            core_result = {4{$urandom}};
            step();
        end
        core_valid = 1'b0;
        check_val("dd_length", n, MW);
        check_val("miso_stream", got, exp_q.pop_front());
        check_val("miso_after_frame", Miso, 0);
        check_val("busy_after_frame", busy, 0);
        check_val("idle_after_frame", dbg_state, 0);
        cs = 1'b1;
        step();
        check_val("stay_idle_cs_high", busy, 0);
        check_val("msg_held", core_msg, ref_msg);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [TOT-1:0] r;
        logic [MW-1:0]  res;
        int             starts;

        rst = 1'b1; cs = 1'b1; Mosi = 1'b0; core_valid = 1'b0; core_result = '0;
        ref_msg = '0; ref_key = '0;
        step(); step();
        check_val("rst_msg", core_msg, 0);
        check_val("rst_key", core_key, 0);
        check_val("rst_start", core_start, 0);
        check_val("rst_miso", Miso, 0);
        check_val("rst_dd", data_done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_state", dbg_state, 0);
        rst = 1'b0;
        step();

        // Directed vectors, then valid pulses in IDLE.
        idle_noise(4);
        send_frame(128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0);
        return_result(128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0);

        // Long core latency.
        rand_bits(r);
        send_frame(r[TOT-1:KW], r[KW-1:0], 1'b0);
        res = {$urandom, $urandom, $urandom, $urandom};
        return_result(res, 50, 1'b0);

        // Abort after 200 bits, then a fresh frame.
        starts = 0;
        cs = 1'b0;
        for (int i = 0; i < 200; i++) begin
            Mosi = 1'($urandom);
            step();
            if (core_start) starts++;
        end
        cs = 1'b1;
        step();
        check_val("abort_no_start", starts, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_state", dbg_state, 0);
        check_val("abort_msg_kept", core_msg, ref_msg);
        rand_bits(r);
        send_frame(r[TOT-1:KW], r[KW-1:0], 1'b0);
        res = {$urandom, $urandom, $urandom, $urandom};
        return_result(res, 3, 1'b0);

        // Reset after 40 result bits.
        rand_bits(r);
        send_frame(r[TOT-1:KW], r[KW-1:0], 1'b0);
        core_result = {$urandom, $urandom, $urandom, $urandom};
        core_valid  = 1'b1;
        step();
        core_valid = 1'b0;
        for (int i = 0; i < 39; i++) step();
        check_val("dd_before_rst", data_done, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cs  = 1'b1;
        ref_msg = '0;
        ref_key = '0;
        check_val("rst_send_dd", data_done, 0);
        check_val("rst_send_miso", Miso, 0);
        check_val("rst_send_busy", busy, 0);
        check_val("rst_send_state", dbg_state, 0);
        check_val("rst_send_msg", core_msg, 0);
        step();
        send_frame(128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0);
        return_result(128'h8ea2b7ca516745bfeafc49904b496089, 1, 1'b0);

        // Random frames with stray core_valid pulses in RECV, START and SEND.
        for (int k = 0; k < 4; k++) begin
            idle_noise($urandom_range(1, 3));
            rand_bits(r);
            send_frame(r[TOT-1:KW], r[KW-1:0], 1'b1);
            res = {$urandom, $urandom, $urandom, $urandom};
            return_result(res, $urandom_range(0, 20), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
